// File: rtl/sc_config_pkg.sv
// Shared constants and types for the double-buffered config commit block.
package sc_config_pkg;
  localparam int NUM_CFG_REGS = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_COMMIT = 2'd2
  } commit_state_e;

  localparam int HV_IN_CONFIG    = 0;
  localparam int HV_OUT_CONFIG   = 1;
  localparam int HV_RAMP_CONFIG  = 2;
  localparam int HV_LIMIT_CONFIG = 3;
  localparam int TRIG_CONFIG     = 4;
  localparam int TIMING_CONFIG   = 5;
  localparam int GAIN_CONFIG     = 6;
  localparam int OFFSET_CONFIG   = 7;
  localparam int SL_CONFIG0      = 8;
  localparam int SL_CONFIG1      = 9;
  localparam int SL_CONFIG2      = 10;
  localparam int SL_CONFIG3      = 11;
endpackage

// File: rtl/sc_cfg_bereg.sv
// One 32-bit register with per-byte write enables and async reset.
module sc_cfg_bereg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);
  logic [31:0] r_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q <= '0;
    end else if (we_i) begin
      for (int b = 0; b < 4; b++)
        if (be_i[b]) r_q[8*b +: 8] <= d_i[8*b +: 8];
    end
  end

  assign q_o = r_q;
endmodule

// File: rtl/sc_config_commit.sv
// Shadow/active config bank: software writes shadow, a frame-aligned (or
// timed-out) commit copies the whole shadow set into active in one edge.
module sc_config_commit
  import sc_config_pkg::*;
#(
  parameter int NUM_REGS       = NUM_CFG_REGS,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [3:0]            wr_addr_i,
  input  logic [31:0]           wr_data_i,
  input  logic [3:0]            wr_be_i,
  input  logic                  commit_req_i,
  input  logic                  abort_i,
  input  logic                  frame_start_i,
  output logic [NUM_REGS*32-1:0] active_cfg_o,
  output logic                  pending_o,
  output logic                  commit_done_o,
  output logic                  timeout_o,
  output logic [1:0]            state_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [NUM_REGS-1:0][31:0] w_shadow;
  logic [NUM_REGS-1:0][31:0] r_active;
  commit_state_e             r_state, w_state_nxt;
  logic [CW-1:0]             r_cnt, w_cnt_nxt;
  logic                      r_timeout, r_done;
  logic                      w_commit, w_to_set, w_to_clr;

  // Out-of-range addresses match no instance, so they fall away naturally.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_shadow
    sc_cfg_bereg u_reg (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .we_i  (wr_en_i && (wr_addr_i == 4'(g))),
      .be_i  (wr_be_i),
      .d_i   (wr_data_i),
      .q_o   (w_shadow[g])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    w_to_set    = 1'b0;
    w_to_clr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (commit_req_i) begin
          w_state_nxt = ST_ARMED;
          w_cnt_nxt   = '0;
          w_to_clr    = 1'b1;
        end
      end
      ST_ARMED: begin
        // Frame start outranks the terminal count, so timeout stays clear.
        if (abort_i)                            w_state_nxt = ST_IDLE;
        else if (frame_start_i)                 w_state_nxt = ST_COMMIT;
        else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt = ST_COMMIT;
          w_to_set    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_COMMIT: begin
        w_state_nxt = ST_IDLE;
        w_commit    = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
      r_active  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_commit;
      if (w_to_clr)      r_timeout <= 1'b0;
      else if (w_to_set) r_timeout <= 1'b1;
      if (w_commit)      r_active  <= w_shadow;
    end
  end

  assign active_cfg_o  = r_active;
  assign pending_o     = (r_state == ST_ARMED) || (r_state == ST_COMMIT);
  assign commit_done_o = r_done;
  assign timeout_o     = r_timeout;
  assign state_o       = r_state;
endmodule
